hist_readout: RTL

HIST_READOUT -- requirements
Module: hist_readout

---
 rtl/hist_stream_if.sv | 12 +
 rtl/hist_readout.sv | 139 +++++++++++++
 2 files changed

// File: rtl/hist_stream_if.sv
// Bin-count output stream: valid/ready handshake with a last-beat marker.
interface hist_stream_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/hist_readout.sv
// Histogram RAM readout: sweeps NUM_BINS bins into a backpressured stream through a 2-entry skid FIFO.
// Optional macro HIST_CLEAR_EN zeroes each bin the cycle after it is read.
module hist_readout #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int NUM_BINS = 1024
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] RdAddress,
    output logic              RdClockEn,
    input  logic [DATA_W-1:0] Q,
    output logic [ADDR_W-1:0] WrAddress,
    output logic [DATA_W-1:0] Data,
    output logic              WE,
    output logic              WrClockEn,
    hist_stream_if.master     outStream
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    localparam int             LastInt  = NUM_BINS - 1;
    localparam logic [ADDR_W:0] LAST_IDX = LastInt[ADDR_W:0];

    state_t            state, stateNext;
    logic [ADDR_W:0]   addrCnt, addrCntNext;
    logic [ADDR_W:0]   beatCnt;
    logic              vld_p0;
    logic [1:0]        fifoCnt;
    logic [1:0]        occupancy;
    logic [DATA_W-1:0] fifoMem0, fifoMem1;
    logic              rdEn, outValid, pop, popMem, push, lastBeat, doneNext;

    // Head of the FIFO falls through to Q when nothing is buffered, giving 2-cycle start latency.
    always_comb begin
        outValid  = (fifoCnt != 2'd0) || vld_p0;
        pop       = outValid && outStream.out_ready;
        popMem    = pop && (fifoCnt != 2'd0);
        push      = vld_p0 && !(pop && (fifoCnt == 2'd0));
        lastBeat  = (beatCnt == LAST_IDX);
        occupancy = fifoCnt + {1'b0, vld_p0} - {1'b0, pop};
    end

    assign outStream.out_valid = outValid;
    assign outStream.out_data  = (fifoCnt != 2'd0) ? fifoMem0 : Q;
    assign outStream.out_last  = outValid && lastBeat;
    assign busy      = (state != IDLE);
    assign RdClockEn = rdEn;
    assign RdAddress = addrCnt[ADDR_W-1:0];

    always_comb begin
        stateNext   = state;
        addrCntNext = addrCnt;
        rdEn        = 1'b0;
        doneNext    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext   = READ;
                    addrCntNext = '0;
                end
            end
            READ: begin
                // Beats left after this cycle's pop plus the new read must fit in two slots.
                if (occupancy < 2'd2) begin
                    rdEn        = 1'b1;
                    addrCntNext = addrCnt + 1'b1;
                    if (addrCnt == LAST_IDX) stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && lastBeat) begin
                    stateNext = IDLE;
                    doneNext  = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            addrCnt <= '0;
            beatCnt <= '0;
            vld_p0  <= 1'b0;
            fifoCnt <= 2'd0;
            done    <= 1'b0;
        end else begin
            state   <= stateNext;
            addrCnt <= addrCntNext;
            vld_p0  <= rdEn;
            fifoCnt <= fifoCnt - {1'b0, popMem} + {1'b0, push};
            done    <= doneNext;
            if (state == IDLE && start) beatCnt <= '0;
            else if (pop)               beatCnt <= beatCnt + 1'b1;
        end
    end

    // Stage p0 -> FIFO: capture Q in address order; fill level never exceeds two.
    always_ff @(posedge Clock) begin
        if (popMem) begin
            fifoMem0 <= fifoMem1;
            if (push) begin
                if (fifoCnt == 2'd1) fifoMem0 <= Q;
                else                 fifoMem1 <= Q;
            end
        end else if (push) begin
            if (fifoCnt == 2'd0) fifoMem0 <= Q;
            else                 fifoMem1 <= Q;
        end
    end

`ifdef HIST_CLEAR_EN
    logic              weReg;
    logic [ADDR_W-1:0] wrAddrReg;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            weReg     <= 1'b0;
            wrAddrReg <= '0;
        end else begin
            weReg     <= rdEn;
            wrAddrReg <= RdAddress;
        end
    end

    assign WE        = weReg;
    assign WrClockEn = weReg;
    assign WrAddress = wrAddrReg;
`else
    assign WE        = 1'b0;
    assign WrClockEn = 1'b0;
    assign WrAddress = '0;
`endif
    assign Data = '0;
endmodule
